multi_clk_divgen: RTL

// - Parametrised soft clock generator, successor to the fixed two-output PLL wrapper.
// - Derives NUM_CLKS divided clock signals and clock-enable strobes from refclk.
// - Divide ratio and phase of each channel are runtime-reconfigurable through a valid/ready port.
// - Outputs are gated by an upstream PLL lock, and the block reports its own lock once outputs are stable.

---
 rtl/multi_clk_divgen_if.sv | 28 ++
 rtl/multi_clk_divgen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multi_clk_divgen_if.sv
// Configuration port of multi_clk_divgen: one valid/ready request carrying
// per-channel divide ratios and phases, plus a one-cycle reject pulse.
interface multi_clk_divgen_if #(
    parameter int NUM_CLKS = 2,
    parameter int DIV_W    = 8
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [NUM_CLKS*DIV_W-1:0] cfg_div;
    logic [NUM_CLKS*DIV_W-1:0] cfg_phase;
    logic                      cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_phase,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_phase,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/multi_clk_divgen.sv
// Soft clock generator: NUM_CLKS divided clocks and enable strobes from refclk,
// runtime divide/phase reconfiguration, gated by a synchronised upstream lock.
module multi_clk_divgen #(
    parameter int NUM_CLKS    = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int RST_DIV     = 4,
    parameter int RST_PHASE   = 0
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                ref_locked,
    multi_clk_divgen_if.slave   cfg,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] ce,
    output logic                locked
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_REF = 2'd0,
        SETTLE   = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 sync_meta_r;
    logic                 ref_sync_r;
    logic [LCW-1:0]       lock_cnt_r;
    logic                 locked_r;
    logic                 cfg_err_r;
    logic [NUM_CLKS-1:0]  outclk_r;
    logic [NUM_CLKS-1:0]  ce_r;
    logic [DIV_W-1:0]     div_r   [NUM_CLKS];
    logic [DIV_W-1:0]     phase_r [NUM_CLKS];
    logic [DIV_W-1:0]     cnt_r   [NUM_CLKS];

    logic                 ready_s;
    logic                 cfg_bad_s;
    logic                 accept_s;
    logic                 load_s;
    logic                 run_s;

    // A request is rejected if any enabled channel starts at or beyond its own period.
    function automatic logic cfg_invalid(input logic [NUM_CLKS*DIV_W-1:0] d,
                                         input logic [NUM_CLKS*DIV_W-1:0] p);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_CLKS; i++) begin
            if ((d[i*DIV_W +: DIV_W] != {DIV_W{1'b0}}) &&
                (p[i*DIV_W +: DIV_W] >= d[i*DIV_W +: DIV_W])) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // High-phase length: ceil(N/2), widened so N = 2**DIV_W-1 cannot overflow.
    function automatic logic [DIV_W:0] half_up(input logic [DIV_W-1:0] n);
        return ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
    endfunction

    // Request decode and run qualifier; a falling ref_s stops outputs without waiting for the state change.
    always_comb begin
        ready_s   = (state_r != SETTLE);
        cfg_bad_s = cfg_invalid(cfg.cfg_div, cfg.cfg_phase);
        accept_s  = cfg.cfg_valid && ready_s;
        load_s    = accept_s && !cfg_bad_s;
        run_s     = (state_r != WAIT_REF) && ref_sync_r;
    end

    // Next-state logic; loss of upstream lock overrides any configuration event.
    always_comb begin
        state_nxt_s = state_r;
        if (!ref_sync_r) begin
            state_nxt_s = WAIT_REF;
        end else begin
            case (state_r)
                WAIT_REF: begin
                    if (load_s) state_nxt_s = WAIT_REF;
                    else        state_nxt_s = SETTLE;
                end
                SETTLE: begin
                    if (lock_cnt_r == LOCK_LAST) state_nxt_s = LOCKED;
                    else                         state_nxt_s = SETTLE;
                end
                LOCKED: begin
                    if (load_s) state_nxt_s = SETTLE;
                    else        state_nxt_s = LOCKED;
                end
                default: state_nxt_s = WAIT_REF;
            endcase
        end
    end

    // Synchroniser, state register, settle counter and status flags.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            ref_sync_r  <= 1'b0;
            state_r     <= WAIT_REF;
            lock_cnt_r  <= {LCW{1'b0}};
            locked_r    <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            sync_meta_r <= ref_locked;
            ref_sync_r  <= sync_meta_r;
            state_r     <= state_nxt_s;
            cfg_err_r   <= accept_s && cfg_bad_s;
            locked_r    <= (state_nxt_s == LOCKED);
            if ((state_r == SETTLE) && (state_nxt_s == SETTLE)) begin
                lock_cnt_r <= lock_cnt_r + LCW'(1);
            end else begin
                lock_cnt_r <= {LCW{1'b0}};
            end
        end
    end

    // Per-channel config registers, counters and registered clock/enable outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                div_r[i]   <= DIV_W'(RST_DIV);
                phase_r[i] <= DIV_W'(RST_PHASE);
                cnt_r[i]   <= DIV_W'(RST_PHASE);
            end
            outclk_r <= {NUM_CLKS{1'b0}};
            ce_r     <= {NUM_CLKS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                // Reloading every counter on the same edge keeps all channels phase-aligned.
                if (load_s) begin
                    div_r[i]   <= cfg.cfg_div[i*DIV_W +: DIV_W];
                    phase_r[i] <= cfg.cfg_phase[i*DIV_W +: DIV_W];
                    cnt_r[i]   <= cfg.cfg_phase[i*DIV_W +: DIV_W];
                end else if (state_r == WAIT_REF) begin
                    cnt_r[i]   <= phase_r[i];
                end else if (run_s) begin
                    if (cnt_r[i] == (div_r[i] - DIV_W'(1))) cnt_r[i] <= {DIV_W{1'b0}};
                    else                                    cnt_r[i] <= cnt_r[i] + DIV_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
                outclk_r[i] <= run_s && (div_r[i] != {DIV_W{1'b0}}) &&
                               ({1'b0, cnt_r[i]} < half_up(div_r[i]));
                ce_r[i]     <= run_s && (div_r[i] != {DIV_W{1'b0}}) &&
                               (cnt_r[i] == {DIV_W{1'b0}});
            end
        end
    end

    assign outclk        = outclk_r;
    assign ce            = ce_r;
    assign locked        = locked_r;
    assign cfg.cfg_err   = cfg_err_r;
    assign cfg.cfg_ready = ready_s;

endmodule
